// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes and
// instruction classes.
package mc_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU   = 3'd0,
    C_ALUI  = 3'd1,
    C_LOAD  = 3'd2,
    C_STORE = 3'd3,
    C_JUMP  = 3'd4,
    C_HALT  = 3'd5,
    C_ILL   = 3'd6
  } iclass_t;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_ADDI  = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b1001;
  localparam logic [3:0] OP_STORE = 4'b1010;
  localparam logic [3:0] OP_JUMP  = 4'b1100;
  localparam logic [3:0] OP_HALT  = 4'b1111;

endpackage

// File: rtl/mc_control_decode.sv
// Combinational opcode decoder: opcode -> instruction class and zero-extended
// ALU op. Any set bit above the low nibble makes the opcode illegal.
module mc_decode
  import mc_control_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int ALUCW = 2
) (
  input  logic [OPW-1:0]   i_op,
  output iclass_t          o_cls,
  output logic [ALUCW-1:0] o_aluc
);

  logic w_hi;
  assign w_hi = ((i_op >> 4) != '0);

  always_comb begin
    o_cls  = C_ILL;
    o_aluc = '0;
    case (i_op[3:0])
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        o_cls       = C_ALU;
        o_aluc[1:0] = i_op[1:0];
      end
      OP_ADDI:  o_cls = C_ALUI;
      OP_LOAD:  o_cls = C_LOAD;
      OP_STORE: o_cls = C_STORE;
      OP_JUMP:  o_cls = C_JUMP;
      OP_HALT:  o_cls = C_HALT;
      default:  o_cls = C_ILL;
    endcase
    if (w_hi) begin
      o_cls  = C_ILL;
      o_aluc = '0;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit with retired-instruction
// counter. Define MC_CONTROL_STALL_EN to honour the mem_rdy handshake.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OPW   = 4,
  parameter int ALUCW = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcd,
  input  logic             mem_rdy,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             selc_a,
  output logic             selc_b,
  output logic [ALUCW-1:0] aluc,
  output logic             we,
  output logic             illegal,
  output logic             halted,
  output logic [CNTW-1:0]  icount
);

  state_t           r_state;
  logic [OPW-1:0]   r_lop;
  logic [CNTW-1:0]  r_icount;
  iclass_t          w_in_cls;
  iclass_t          w_cls;
  logic [ALUCW-1:0] w_unused_aluc;
  logic [ALUCW-1:0] w_aluc;
  logic             w_rdy;

`ifdef MC_CONTROL_STALL_EN
  assign w_rdy = mem_rdy;
`else
  logic w_unused_rdy;
  assign w_unused_rdy = mem_rdy;
  assign w_rdy        = 1'b1;
`endif

  // Live opcode is only looked at in DECODE; everything later uses the latched copy.
  mc_decode #(.OPW(OPW), .ALUCW(ALUCW)) u_dec_in (
    .i_op(opcd), .o_cls(w_in_cls), .o_aluc(w_unused_aluc)
  );

  mc_decode #(.OPW(OPW), .ALUCW(ALUCW)) u_dec_lop (
    .i_op(r_lop), .o_cls(w_cls), .o_aluc(w_aluc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_lop    <= '0;
      r_icount <= '0;
    end else begin
      case (r_state)
        S_FETCH: if (w_rdy) r_state <= S_DECODE;
        S_DECODE: begin
          r_lop <= opcd;
          if (w_in_cls == C_HALT)     r_state <= S_HALT;
          else if (w_in_cls == C_ILL) r_state <= S_FETCH;
          else                        r_state <= S_EXEC;
        end
        S_EXEC: begin
          case (w_cls)
            C_ALU, C_ALUI:   r_state <= S_WB;
            C_LOAD, C_STORE: r_state <= S_MEM;
            C_JUMP: begin
              r_state  <= S_FETCH;
              r_icount <= r_icount + CNTW'(1);
            end
            default:         r_state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (w_rdy) begin
            if (w_cls == C_STORE) begin
              r_state  <= S_FETCH;
              r_icount <= r_icount + CNTW'(1);
            end else begin
              r_state <= S_WB;
            end
          end
        end
        S_WB: begin
          r_state  <= S_FETCH;
          r_icount <= r_icount + CNTW'(1);
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // ir_ld/pc_inc are gated by rst so nothing but mem_req is visible while in reset.
  always_comb begin
    mem_req = 1'b0;
    mem_we  = 1'b0;
    ir_ld   = 1'b0;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    selc_a  = 1'b0;
    selc_b  = 1'b0;
    aluc    = '0;
    we      = 1'b0;
    illegal = 1'b0;
    halted  = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_ld   = w_rdy & rst;
        pc_inc  = w_rdy & rst;
      end
      S_DECODE: illegal = (w_in_cls == C_ILL);
      S_EXEC: begin
        pc_ld  = (w_cls == C_JUMP);
        selc_b = (w_cls == C_ALUI) || (w_cls == C_LOAD) || (w_cls == C_STORE);
        aluc   = w_aluc;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_cls == C_STORE);
      end
      S_WB: begin
        we     = 1'b1;
        selc_b = (w_cls == C_ALUI) || (w_cls == C_LOAD);
        aluc   = w_aluc;
      end
      S_HALT:  halted = 1'b1;
      default: mem_req = 1'b0;
    endcase
  end

  assign icount = r_icount;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: directed instruction sequences push the
// expected per-cycle strobes; a monitor pops and compares every cycle.
module tb_mc_control;

`ifdef MC_CONTROL_STALL_EN
  localparam bit STALL = 1'b1;
`else
  localparam bit STALL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_rdy;
  logic [4:0] opcd;
  logic       mem_req, mem_we, ir_ld, pc_inc, pc_ld, selc_a, selc_b, we, illegal, halted;
  logic [1:0] aluc;
  logic [1:0] icount;

  mc_control #(.OPW(5), .ALUCW(2), .CNTW(2)) dut (
    .clk(clk), .rst(rst), .opcd(opcd), .mem_rdy(mem_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .ir_ld(ir_ld), .pc_inc(pc_inc),
    .pc_ld(pc_ld), .selc_a(selc_a), .selc_b(selc_b), .aluc(aluc), .we(we),
    .illegal(illegal), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  // {mem_req, mem_we, ir_ld, pc_inc, pc_ld, selc_a, selc_b, aluc[1:0], we, illegal, halted}
  localparam logic [11:0] V_REQ   = 12'h800;
  localparam logic [11:0] V_MWE   = 12'h400;
  localparam logic [11:0] V_IRLD  = 12'h200;
  localparam logic [11:0] V_PCINC = 12'h100;
  localparam logic [11:0] V_PCLD  = 12'h080;
  localparam logic [11:0] V_SB    = 12'h020;
  localparam logic [11:0] V_WE    = 12'h004;
  localparam logic [11:0] V_ILL   = 12'h002;
  localparam logic [11:0] V_HLT   = 12'h001;
  localparam logic [4:0]  JUNK    = 5'b01111;  // HALT code: must be ignored outside DECODE

  typedef struct {
    string      name;
    logic [11:0] v;
    logic [1:0]  c;
  } exp_t;

  exp_t       q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] cnt    = 2'd0;

  wire [11:0] w_act = {mem_req, mem_we, ir_ld, pc_inc, pc_ld, selc_a, selc_b,
                       aluc, we, illegal, halted};

  function automatic logic [11:0] A(input logic [1:0] k);
    return {7'b0, k, 3'b000};
  endfunction

  task automatic chk(input string nm, input logic [11:0] av, input logic [11:0] ev,
                     input logic [1:0] ac, input logic [1:0] ec);
    n_chk++;
    if (av !== ev || ac !== ec) begin
      n_fail++;
      $display("FAIL %s: got outputs=%03h icount=%0d, required outputs=%03h icount=%0d",
               nm, av, ac, ev, ec);
    end
  endtask

  task automatic cyc(input string nm, input logic [4:0] op, input logic rdy,
                     input logic [11:0] ev);
    @(negedge clk);
    opcd    = op;
    mem_rdy = rdy;
    q.push_back('{name: nm, v: ev, c: cnt});
  endtask

  task automatic fetch(input int stalls, input string nm);
    if (STALL) begin
      repeat (stalls) cyc({nm, "_fetch_stall"}, JUNK, 1'b0, V_REQ);
      cyc({nm, "_fetch"}, JUNK, 1'b1, V_REQ | V_IRLD | V_PCINC);
    end else begin
      cyc({nm, "_fetch"}, JUNK, (stalls == 0), V_REQ | V_IRLD | V_PCINC);
    end
  endtask

  task automatic memc(input int stalls, input string nm, input logic [11:0] ev);
    if (STALL) begin
      repeat (stalls) cyc({nm, "_mem_stall"}, JUNK, 1'b0, ev);
      cyc({nm, "_mem"}, JUNK, 1'b1, ev);
    end else begin
      cyc({nm, "_mem"}, JUNK, (stalls == 0), ev);
    end
  endtask

  task automatic alu(input logic [1:0] k, input string nm);
    fetch(0, nm);
    cyc({nm, "_dec"}, {3'b000, k}, 1'b0, 12'h000);
    cyc({nm, "_exec"}, JUNK, 1'b0, A(k));
    cyc({nm, "_wb"}, JUNK, 1'b0, V_WE | A(k));
    cnt = cnt + 2'd1;
  endtask

  // Asynchronous reset asserted mid-cycle, checked immediately, then released.
  task automatic reset_now(input string nm);
    #3 rst = 1'b0;
    #1 chk({nm, "_async"}, w_act, V_REQ, icount, 2'd0);
    cnt = 2'd0;
    cyc({nm, "_hold"}, JUNK, 1'b1, V_REQ);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, w_act, e.v, icount, e.c);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    rst     = 1'b0;
    mem_rdy = 1'b1;
    opcd    = JUNK;
    cyc("reset0", JUNK, 1'b1, V_REQ);
    cyc("reset1", JUNK, 1'b1, V_REQ);
    @(posedge clk);
    #2 rst = 1'b1;

    alu(2'd1, "sub");

    fetch(1, "load");
    cyc("load_dec", 5'b01001, 1'b0, 12'h000);
    cyc("load_exec", JUNK, 1'b0, V_SB);
    memc(3, "load", V_REQ);
    cyc("load_wb", JUNK, 1'b0, V_WE | V_SB);
    cnt = cnt + 2'd1;

    fetch(0, "store");
    cyc("store_dec", 5'b01010, 1'b0, 12'h000);
    cyc("store_exec", JUNK, 1'b0, V_SB);
    memc(1, "store", V_REQ | V_MWE);
    cnt = cnt + 2'd1;

    fetch(0, "jump");
    cyc("jump_dec", 5'b01100, 1'b0, 12'h000);
    cyc("jump_exec", JUNK, 1'b0, V_PCLD);
    cnt = cnt + 2'd1;

    alu(2'd0, "add");
    alu(2'd2, "and");
    alu(2'd3, "or");

    fetch(0, "addi");
    cyc("addi_dec", 5'b00100, 1'b0, 12'h000);
    cyc("addi_exec", JUNK, 1'b0, V_SB);
    cyc("addi_wb", JUNK, 1'b0, V_WE | V_SB);
    cnt = cnt + 2'd1;

    fetch(0, "ill0110");
    cyc("ill0110_dec", 5'b00110, 1'b0, V_ILL);
    fetch(0, "ill10000");
    cyc("ill10000_dec", 5'b10000, 1'b0, V_ILL);
    fetch(0, "ill10001");
    cyc("ill10001_dec", 5'b10001, 1'b0, V_ILL);

    fetch(0, "ldrst");
    cyc("ldrst_dec", 5'b01001, 1'b0, 12'h000);
    cyc("ldrst_exec", JUNK, 1'b0, V_SB);
    cyc("ldrst_mem", JUNK, 1'b0, V_REQ);
    reset_now("rst_mid_mem");

    for (int i = 0; i < 5; i++) alu(2'(i), $sformatf("wrap%0d", i));

    fetch(0, "halt");
    cyc("halt_dec", 5'b01111, 1'b0, 12'h000);
    for (int i = 0; i < 20; i++)
      cyc($sformatf("halted%0d", i), 5'(i), 1'(i & 1), V_HLT);
    reset_now("rst_halt");

    alu(2'd1, "post_rst");

    repeat (3) @(negedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending entries, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Parametrised multi-cycle successor to the single-cycle `control` unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects, the ALU op and the register write enable. It handshakes with instruction/data memory, flags illegal opcodes, halts on HALT and counts retired instructions. It sits between the instruction register and the datapath.

## Interface
- `OPW`, 4: opcode width, ≥4.
- `ALUCW`, 2: ALU control width, ≥2.
- `CNTW`, 16: retired-instruction counter width.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `opcd  in  OPW`: opcode from the IR; sampled only in DECODE.
- `mem_rdy  in  1`: memory completes the current request this cycle.
- `mem_req  out  1`: memory request (fetch or data).
- `mem_we  out  1`: data write (STORE).
- `ir_ld  out  1`: load the IR.
- `pc_inc  out  1`: increment PC.
- `pc_ld  out  1`: load PC from the jump target.
- `selc_a  out  1`: ALU A select (0=reg, 1=PC).
- `selc_b  out  1`: ALU B select (0=reg, 1=immediate).
- `aluc  out  ALUCW`: ALU op, zero-extended.
- `we  out  1`: register-file write enable.
- `illegal  out  1`: one-cycle pulse on an undefined opcode.
- `halted  out  1`: in HALT.
- `icount  out  CNTW`: retired instructions; wraps.

## Operation
- Opcodes. Low 4 bits hold the code. Any nonzero upper bit makes the opcode illegal.
  - 0000–0011: ADD/SUB/AND/OR, reg-reg, `aluc`=opcd[1:0].
  - 0100: ADDI, `selc_b`=1, `aluc`=00.
  - 1001: LOAD. 1010: STORE. 1100: JUMP. 1111: HALT.
  - All other codes are illegal.
- DECODE latches the opcode into `lop`. All later outputs derive from state and `lop` only (Moore).
- FETCH: `mem_req`=1. When `mem_rdy`: `ir_ld`=1, `pc_inc`=1, next state DECODE.
- DECODE, one cycle:
  - HALT → HALT.
  - Illegal → FETCH, with `illegal`=1 in this cycle.
  - Otherwise → EXEC.
- EXEC, one cycle:
  - ALU/ADDI: drive `selc_a`=0, `selc_b`, `aluc`; → WB.
  - LOAD/STORE: `selc_b`=1, `aluc`=00 (address add); → MEM.
  - JUMP: `pc_ld`=1; → FETCH; retires.
- MEM: `mem_req`=1, `mem_we`=1 for STORE, held until `mem_rdy`. Then LOAD → WB; STORE → FETCH and retires.
- WB: `we`=1 for one cycle, `selc_b`/`aluc` held from EXEC; → FETCH; retires.
- HALT: all strobes 0, `halted`=1. Exits only on reset.
- Retire: `icount` += 1 on the clock edge leaving the final state. All-ones wraps to 0. HALT and illegal opcodes do not retire.
- Outside the states listed above, every strobe is 0.

## Timing
- Reset (`rst`=0, asynchronous, including mid-instruction):
  - State becomes FETCH; `lop`=0; `icount`=0.
  - All outputs 0, except `mem_req`=1 combinationally from FETCH.
  - Any in-flight MEM request is dropped.
- Latency with `mem_rdy` tied 1: ALU/ADDI 4 cycles, LOAD 5, STORE 4, JUMP 3.
- Each `mem_rdy`-low cycle in FETCH or MEM adds one cycle. `mem_req` stays high and the other strobes hold.
- `mem_rdy` is ignored outside FETCH/MEM.
- `opcd` changes outside DECODE have no effect.

## Configuration
- `MC_CONTROL_STALL_EN` defined: `mem_rdy` handshake as above.
- Undefined: `mem_rdy` is treated as 1. FETCH and MEM always take exactly one cycle, and the port exists but is ignored.

## Structure
- `mc_control_pkg` holds:
  - the state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - the opcode constants;
  - the instruction-class encoding (ALU, ALUI, LOAD, STORE, JUMP, HALT, ILL).
- Sub-module `mc_decode`: combinational opcd → class plus ALU op, parametrised by `OPW`/`ALUCW`.

## Test plan
- Release reset with `mem_rdy`=1 and opcd 0001 → `mem_req`=1 in FETCH; `aluc`=01, `we`=1 in cycle 4; `icount`=1.
- opcd 1001, `mem_rdy` low for 3 MEM cycles (STALL_EN) → `mem_req` high for 4 MEM cycles, `mem_we`=0; `we` in cycle 8.
- opcd 1010 → `mem_we`=1 in MEM, `we` never asserted. opcd 1100 → `pc_ld`=1 in cycle 3.
- opcd 0110, and 1_0000 with `OPW`=5 → `illegal` pulses once, `icount` unchanged, next FETCH follows.
- opcd 1111 → `halted`=1 and held for 20 cycles. Then reset → FETCH with `icount`=0.
- `CNTW`=2, five ALU instructions → `icount` reads 1,2,3,0,1. Reset asserted mid-MEM → all outputs 0 except `mem_req`, immediately.
